// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between two masters for the single-port data RAM.
// Maps MIPS byte addresses from BASE upward onto RAM word indices, one access every two cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DEPTH  = 2048,
  parameter logic [31:0] BASE   = 32'h1001_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request context kept from arbitration until its response is issued.
  typedef struct packed {
    logic id;
    logic we;
    logic err;
  } xfer_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  xfer_t             xfer_q, xfer_d;

  logic              m0_gnt_d, m1_gnt_d;
  logic              m0_rvalid_d, m1_rvalid_d;
  logic              m0_err_d, m1_err_d;
  logic [DW-1:0]     m0_rdata_d, m1_rdata_d;
  logic              mem_wena_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DW-1:0]     mem_wdata_d;

  logic              win;
  logic              sel_we;
  logic [DW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [DW-1:0]     offset;
  logic [DW-1:0]     idx;
  logic              sel_err;
  logic [DW-1:0]     rsp_data;

  // Winner selection and address decode for the request about to be captured.
  always_comb begin
    win       = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    offset    = sel_addr - BASE;
    idx       = offset >> 2;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr < BASE) || (idx >= DW'(DEPTH));
    rsp_data  = (xfer_q.we || xfer_q.err) ? '0 : mem_rdata;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    xfer_d       = xfer_q;
    m0_gnt_d     = 1'b0;
    m1_gnt_d     = 1'b0;
    m0_rvalid_d  = 1'b0;
    m1_rvalid_d  = 1'b0;
    m0_err_d     = 1'b0;
    m1_err_d     = 1'b0;
    m0_rdata_d   = '0;
    m1_rdata_d   = '0;
    mem_wena_d   = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;

    case (state_q)
      IDLE, RESP: begin
        if (m0_req || m1_req) begin
          state_d      = ACCESS;
          last_grant_d = win;
          xfer_d.id    = win;
          xfer_d.we    = sel_we;
          xfer_d.err   = sel_err;
          m0_gnt_d     = ~win;
          m1_gnt_d     = win;
          mem_wena_d   = sel_we && !sel_err;
          if (!sel_err) begin
            mem_addr_d  = idx[ADDR_W-1:0];
            mem_wdata_d = sel_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (xfer_q.id) begin
          m1_rvalid_d = 1'b1;
          m1_err_d    = xfer_q.err;
          m1_rdata_d  = rsp_data;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_err_d    = xfer_q.err;
          m0_rdata_d  = rsp_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears everything at once, so an in-flight write never reaches the RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      xfer_q       <= '0;
      m0_gnt       <= 1'b0;
      m1_gnt       <= 1'b0;
      m0_rvalid    <= 1'b0;
      m1_rvalid    <= 1'b0;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
      mem_wena     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      xfer_q       <= xfer_d;
      m0_gnt       <= m0_gnt_d;
      m1_gnt       <= m1_gnt_d;
      m0_rvalid    <= m0_rvalid_d;
      m1_rvalid    <= m1_rvalid_d;
      m0_err       <= m0_err_d;
      m1_err       <= m1_err_d;
      m0_rdata     <= m0_rdata_d;
      m1_rdata     <= m1_rdata_d;
      mem_wena     <= mem_wena_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks of dmem_arbiter against a
// transaction-level model (round-robin rule, address window, shadow memory).
module tb_dmem_arbiter;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 2048;
  localparam logic [31:0] BASE   = 32'h1001_0000;

  logic              clk, reset;
  logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0]       m0_addr, m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0]       m1_addr, m1_wdata, m1_rdata;
  logic              mem_wena;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  logic [31:0]       ram     [DEPTH];
  logic [31:0]       ref_mem [DEPTH];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [31:0]       pre_data;

  logic              pend_we   [2];
  logic [31:0]       pend_addr [2];
  logic [31:0]       pend_wd   [2];

  int checks;
  int failures;
  bit model_last;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_wena(mem_wena), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with combinational read; preload port used only under reset.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_wena) ram[mem_addr] <= mem_wdata;
  end

  function automatic bit addr_err(input logic [31:0] a);
    longint la = a;
    longint lo = BASE;
    longint hi = longint'(BASE) + 4 * longint'(DEPTH);
    return (la % 4 != 0) || (la < lo) || (la >= hi);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    longint la = a;
    longint lb = BASE;
    return int'((la - lb) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned k = $urandom_range(0, 9);
    case (k)
      0: return BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
      1: return BASE - 32'($urandom_range(1, 64) * 4);
      2: return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64) * 4);
      3: return BASE + 32'((DEPTH - 1) * 4);
      default: return BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
    endcase
  endfunction

  function automatic logic gnt_of(input bit m);    return m ? m1_gnt    : m0_gnt;    endfunction
  function automatic logic rvalid_of(input bit m); return m ? m1_rvalid : m0_rvalid; endfunction
  function automatic logic err_of(input bit m);    return m ? m1_err    : m0_err;    endfunction
  function automatic logic [31:0] rdata_of(input bit m); return m ? m1_rdata : m0_rdata; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit m, input logic req, input logic we,
                       input logic [31:0] a, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
    end
  endtask

  task automatic check_access(input bit w, input logic we, input logic [31:0] a,
                              input logic [31:0] wd);
    bit e = addr_err(a);
    chk("gnt_winner", 32'(gnt_of(w)), 32'd1);
    chk("gnt_other", 32'(gnt_of(!w)), 32'd0);
    chk("rvalid_in_access", 32'(rvalid_of(w)), 32'd0);
    chk("mem_wena_access", 32'(mem_wena), 32'(we && !e));
    if (!e) chk("mem_addr", 32'(mem_addr), 32'(word_of(a)));
    if (we && !e) chk("mem_wdata", mem_wdata, wd);
  endtask

  task automatic check_resp(input bit w, input logic we, input logic [31:0] a,
                            input logic [31:0] wd);
    bit e = addr_err(a);
    logic [31:0] exp_rd = 32'h0;
    if (!we && !e) exp_rd = ref_mem[word_of(a)];
    chk("rvalid_winner", 32'(rvalid_of(w)), 32'd1);
    chk("rvalid_other", 32'(rvalid_of(!w)), 32'd0);
    chk("gnt_in_resp", 32'(gnt_of(w)), 32'd0);
    chk("err", 32'(err_of(w)), 32'(e));
    chk("rdata", rdata_of(w), exp_rd);
    chk("rdata_other", rdata_of(!w), 32'h0);
    chk("mem_wena_resp", 32'(mem_wena), 32'd0);
    if (we && !e) ref_mem[word_of(a)] = wd;
  endtask

  task automatic single(input bit m, input logic we, input logic [31:0] a, input logic [31:0] wd);
    drive(m, 1'b1, we, a, wd);
    step();
    model_last = m;
    check_access(m, we, a, wd);
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_resp(m, we, a, wd);
    step();
    chk("rvalid_after_resp", 32'(rvalid_of(m)), 32'd0);
  endtask

  // Both masters keep requesting; the one not served last must win every round.
  task automatic contention(input int n);
    bit w = 1'b0;
    logic cur_we;
    logic [31:0] cur_addr, cur_wd;
    drive(1'b0, 1'b1, pend_we[0], pend_addr[0], pend_wd[0]);
    drive(1'b1, 1'b1, pend_we[1], pend_addr[1], pend_wd[1]);
    for (int k = 0; k < n; k++) begin
      step();
      w = !model_last;
      model_last = w;
      check_access(w, pend_we[w], pend_addr[w], pend_wd[w]);
      cur_we = pend_we[w]; cur_addr = pend_addr[w]; cur_wd = pend_wd[w];
      pend_we[w] = 1'($urandom_range(0, 1));
      pend_addr[w] = rand_addr();
      pend_wd[w] = $urandom;
      drive(w, 1'b1, pend_we[w], pend_addr[w], pend_wd[w]);
      step();
      check_resp(w, cur_we, cur_addr, cur_wd);
    end
    drive(w, 1'b0, 1'b0, 32'h0, 32'h0);
    w = !w;
    step();
    model_last = w;
    check_access(w, pend_we[w], pend_addr[w], pend_wd[w]);
    drive(w, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_resp(w, pend_we[w], pend_addr[w], pend_wd[w]);
    step();
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    bit          m;
    logic        we;
    checks = 0;
    failures = 0;
    model_last = 1'b1;
    reset = 1'b0;
    pre_we = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = ADDR_W'(i);
      pre_data = (i == 3) ? 32'hDEAD_BEEF : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;

    // Reset values, also with requests pending while reset is held.
    drive(1'b0, 1'b1, 1'b1, BASE, 32'h1111_1111);
    drive(1'b1, 1'b1, 1'b1, BASE + 32'd4, 32'h2222_2222);
    step();
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rst_m0_err", 32'(m0_err), 32'd0);
    chk("rst_m1_err", 32'(m1_err), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_mem_wena", 32'(mem_wena), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    step();

    // Contention from reset: m0 first (reads the preloaded word 3), then alternation.
    pend_we[0] = 1'b0; pend_addr[0] = 32'h1001_000C; pend_wd[0] = 32'h0;
    pend_we[1] = 1'b1; pend_addr[1] = BASE + 32'h40; pend_wd[1] = $urandom;
    contention(10);

    // Write then read on master 1, then the address-window corner cases.
    single(1'b1, 1'b1, 32'h1001_0010, 32'h1234_5678);
    single(1'b1, 1'b0, 32'h1001_0010, 32'h0);
    chk("m1_readback_const", ref_mem[4], 32'h1234_5678);
    single(1'b0, 1'b1, 32'h1001_0002, 32'hBAD0_BAD0);
    single(1'b0, 1'b0, 32'h1001_0002, 32'h0);
    single(1'b1, 1'b0, 32'h1000_FFFC, 32'h0);
    single(1'b0, 1'b1, 32'h1001_2000, 32'h5555_AAAA);
    single(1'b1, 1'b1, 32'h1001_1FFC, 32'hA5A5_5A5A);
    single(1'b0, 1'b0, 32'h1001_1FFC, 32'h0);

    // Back-to-back: m0 re-requests during its own RESP cycle.
    drive(1'b0, 1'b1, 1'b0, BASE + 32'h100, 32'h0);
    step();
    model_last = 1'b0;
    check_access(1'b0, 1'b0, BASE + 32'h100, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_resp(1'b0, 1'b0, BASE + 32'h100, 32'h0);
    drive(1'b0, 1'b1, 1'b0, BASE + 32'h104, 32'h0);
    step();
    check_access(1'b0, 1'b0, BASE + 32'h104, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_resp(1'b0, 1'b0, BASE + 32'h104, 32'h0);
    step();

    for (int i = 0; i < 40; i++) begin
      m  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = rand_addr();
      wd = $urandom;
      single(m, we, a, wd);
    end

    // Reset during ACCESS aborts the write and its response.
    a  = BASE + 32'h20;
    wd = ~ref_mem[8];
    drive(1'b0, 1'b1, 1'b1, a, wd);
    step();
    check_access(1'b0, 1'b1, a, wd);
    reset = 1'b0;
    #1;
    chk("abort_mem_wena", 32'(mem_wena), 32'd0);
    chk("abort_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("abort_ram_unchanged", ram[8], ref_mem[8]);
    chk("abort_no_rvalid", 32'(m0_rvalid), 32'd0);
    step();
    chk("abort_no_rvalid2", 32'(m0_rvalid), 32'd0);
    reset = 1'b1;
    model_last = 1'b1;
    step();
    single(1'b0, 1'b0, a, 32'h0);

    pend_we[0] = 1'($urandom_range(0, 1)); pend_addr[0] = rand_addr(); pend_wd[0] = $urandom;
    pend_we[1] = 1'($urandom_range(0, 1)); pend_addr[1] = rand_addr(); pend_wd[1] = $urandom;
    contention(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
